// File: rtl/frame_scanout_reader.sv
// frame_scanout_reader
//   Read side of the 160x120 virtual frame buffer. Whole virtual rows are
//   fetched from frame memory into ping-pong line buffers. Each virtual
//   pixel is then replayed 4x4 to the VGA colour path, using the frame
//   driver's x/y position.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   x, y            current VGA column / line from the frame driver
//   active_pixels   high inside the visible area
//   frame_done      one-cycle pulse at end of frame
//   rd_mem_address  memory read address (row*VIRT_W + col)
//   rd_req          read request, held until rd_valid
//   rd_data         read data, valid with rd_valid
//   rd_valid        one-cycle data-return strobe
//   pix_rgb         pixel colour (1-cycle latency)
//   pix_valid       pix_rgb is an active pixel
//   underrun        sticky: a row fetch was still running when the next one was needed
//   fetch_busy      fetcher is not idle
module frame_scanout_reader #(
  parameter int VIRT_W = 160,
  parameter int VIRT_H = 120,
  parameter int VGA_H  = 480,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active_pixels,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] rd_mem_address,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_valid,
  output logic              underrun,
  output logic              fetch_busy
);

  localparam logic [7:0] LAST_COL  = 8'(VIRT_W - 1);
  localparam logic [7:0] VIRT_W_8  = 8'(VIRT_W);
  localparam logic [8:0] VIRT_H_9  = 9'(VIRT_H);
  localparam logic [9:0] VGA_H_10  = 10'(VGA_H);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state;
  logic        front_sel;
  logic [7:0]  prev_vrow;
  logic [7:0]  col;

  logic [DATA_W-1:0] buf0 [VIRT_W];
  logic [DATA_W-1:0] buf1 [VIRT_W];

  logic [7:0]        vrow;
  logic [7:0]        vcol;
  logic [8:0]        next_vrow;
  logic              row_change;
  logic              start;
  logic [7:0]        start_row;
  logic [ADDR_W-1:0] start_addr;
  logic              buf_we;
  logic [DATA_W-1:0] front_word;

  assign vrow       = y[9:2];
  assign vcol       = x[9:2];
  assign next_vrow  = {1'b0, vrow} + 9'd1;
  assign row_change = (y < VGA_H_10) && (vrow != prev_vrow);

  // A frame_done pulse takes priority over a row change: the next thing shown is row 0.
  assign start      = frame_done || (row_change && (next_vrow < VIRT_H_9));
  assign start_row  = frame_done ? 8'd0 : next_vrow[7:0];
  assign start_addr = ADDR_W'(start_row) * ADDR_W'(VIRT_W);

  // A restarted fetch must not take the return of the abandoned request.
  assign buf_we     = (state == REQ) && rd_valid && !start;

  assign rd_req     = (state == REQ);
  assign fetch_busy = (state != IDLE);

  // Row tracking, buffer swap and fetcher state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      front_sel      <= 1'b0;
      prev_vrow      <= 8'hFF;
      col            <= 8'd0;
      rd_mem_address <= '0;
      underrun       <= 1'b0;
    end else begin
      if (frame_done) begin
        prev_vrow <= 8'hFF;
      end else if (row_change) begin
        prev_vrow <= vrow;
        front_sel <= ~front_sel;
      end

      if (start) begin
        if (state != IDLE) begin
          underrun <= 1'b1;
        end
        state          <= REQ;
        col            <= 8'd0;
        rd_mem_address <= start_addr;
      end else begin
        case (state)
          IDLE: begin
            col <= col;
          end
          REQ: begin
            if (rd_valid) begin
              if (col == LAST_COL) begin
                state <= IDLE;
              end else begin
                col            <= col + 8'd1;
                rd_mem_address <= rd_mem_address + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Line-buffer write port: the fetcher always fills the back buffer.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      if (front_sel) begin
        buf0[col] <= rd_data;
      end else begin
        buf1[col] <= rd_data;
      end
    end
  end

  // Front-buffer read. Columns past the row width read as black.
  always_comb begin
    front_word = {DATA_W{1'b0}};
    if (vcol < VIRT_W_8) begin
      front_word = front_sel ? buf1[vcol] : buf0[vcol];
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_rgb   <= {DATA_W{1'b0}};
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= active_pixels;
      pix_rgb   <= active_pixels ? front_word : {DATA_W{1'b0}};
    end
  end

endmodule

// File: doc/frame_scanout_reader.md
Name: frame_scanout_reader

Overview:
- Read-side counterpart of the frame-buffer write port (15-bit address, 24-bit RGB data, write strobe).
- Fetches the 160x120 virtual frame from frame memory one virtual row at a time into ping-pong line buffers.
- Delivers one 24-bit pixel per clock to the VGA output stage, indexed by the frame driver's x/y; each virtual pixel is replicated 4x4.
- Sits between the frame memory read port and the VGA colour outputs.

Parameters:
- VIRT_W, 160, virtual pixels per row
- VIRT_H, 120, virtual rows per frame
- VGA_H, 480, active VGA lines
- ADDR_W, 15, memory address width
- DATA_W, 24, pixel width (R[23:16], G[15:8], B[7:0])

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous reset, active-high
- x  in  10  current VGA column from frame driver
- y  in  10  current VGA line from frame driver
- active_pixels  in  1  high inside the visible area
- frame_done  in  1  one-cycle pulse at end of frame
- rd_mem_address  out  ADDR_W  read address = row*VIRT_W + col
- rd_req  out  1  read request, held until accepted by rd_valid
- rd_data  in  DATA_W  read data, valid with rd_valid
- rd_valid  in  1  one-cycle data-return strobe for the outstanding request
- pix_rgb  out  DATA_W  pixel colour
- pix_valid  out  1  pix_rgb is an active pixel
- underrun  out  1  sticky: a row fetch did not finish before it was needed
- fetch_busy  out  1  fetcher is not IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; front buffer select 0; prev_vrow=8'hFF; col=0. Line-buffer contents are undefined.
- Two line buffers, each VIRT_W x DATA_W. The display reads the front buffer; the fetcher writes the back buffer.
- vrow = y[9:2]; vcol = x[9:2].
- Row change: y<VGA_H and vrow != prev_vrow, registered each cycle. On a row change:
  - prev_vrow<=vrow; front/back swap.
  - If vrow+1 < VIRT_H, start a fetch of row vrow+1. Otherwise no fetch.
- frame_done pulse: start a fetch of row 0 into the back buffer; prev_vrow<=8'hFF so line 0 triggers a swap.
- Fetcher FSM:
  - IDLE: on a start, latch row, col<=0 -> REQ.
  - REQ: rd_req=1, rd_mem_address=row*VIRT_W+col (computed in ADDR_W bits; max 19199). Wait for rd_valid.
  - On rd_valid: back[col]<=rd_data. If col==VIRT_W-1 -> IDLE; else col+1 and stay in REQ.
  - Exactly one request is outstanding at a time. rd_req stays high across cycles until rd_valid; the address is stable while rd_req=1.
  - rd_valid is ignored in IDLE.
- Start while not IDLE (simultaneous events):
  - underrun<=1 (sticky until rst).
  - The current fetch is abandoned; the new fetch restarts at col=0 for the new row.
  - If the row change and frame_done occur in the same cycle, frame_done wins (fetch row 0).
- Pixel path, 1-cycle latency:
  - pix_rgb <= active_pixels ? front[vcol] : 24'h0.
  - pix_valid <= active_pixels.
  - vcol>=VIRT_W while active is not possible with a 640 width; if it occurs, output black.
- fetch_busy = (state != IDLE).
- Reset mid-fetch: immediate IDLE; rd_req drops asynchronously; a late rd_valid is ignored.

Test Plan:
- Reset: assert rst mid-fetch with rd_req=1 -> rd_req=0, pix_rgb=0, underrun=0, fetch_busy=0 within the same cycle.
- frame_done pulse, memory model returns rd_valid 3 cycles after each request, memory[i]=i -> addresses 0..159 issued in order, fetch_busy falls after the 160th rd_valid. Then y=0, x=8, active -> pix_rgb=24'd2 one cycle later.
- Sweep y 0..7: at y=4 swap, addresses 320..479 fetched (row 2); at y=4, x=636 -> pix_rgb=24'd319; x=4..7 all give the same value.
- Bottom of frame: y=476 (vrow 119) -> swap, no fetch issued; next frame_done -> fetch row 0 (addresses 0..159).
- Slow memory (rd_valid 30 cycles after request) with the row change forced early -> underrun=1 and remains 1; the fetch restarts at col 0 for the new row.
- active_pixels=0 with a full front buffer -> pix_rgb=0, pix_valid=0; rd_valid pulse while IDLE -> no buffer write, no state change.
